// File: rtl/eb_pkg.sv
// Shared definitions for the elastic-buffer family: buffer kinds and the
// credit-counter width helper used by credit-based links.
package eb_pkg;

    // Buffer kinds recognised by generic elastic-buffer wrappers.
    typedef enum logic [1:0] {
        EB_HALF     = 2'd0,
        EB_FULL     = 2'd1,
        EB_TWO_SLOT = 2'd2,
        EB_FIFO     = 2'd3
    } eb_type_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/eb_credit_counter.sv
// Credit counter for the sending end of a credit link. Starts full, decrements
// on a send, increments on a returned credit, saturates at CREDITS and raises a
// sticky overflow flag when a credit arrives that the receiver never owed.
module eb_credit_counter
    import eb_pkg::*;
#(
    parameter  int CREDITS = 4,
    localparam int CW      = credit_width(CREDITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          ovf_s;
    logic          err_r;

    // Next count: a send and a credit in the same cycle cancel out; a credit
    // on a full counter is dropped and flagged instead of wrapping.
    always_comb begin
        cnt_next_s = cnt_r;
        ovf_s      = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r == CW'(CREDITS)) begin
                    cnt_next_s = cnt_r;
                    ovf_s      = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                    ovf_s      = 1'b0;
                end
            end
            2'b01: begin
                // A send is only possible with a credit in hand; holding at
                // zero keeps an illegal decrement from wrapping.
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_next_s = cnt_r - 1'b1;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            2'b11:   cnt_next_s = cnt_r;
            2'b00:   cnt_next_s = cnt_r;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Count and sticky error registers; reset restores a full credit pool.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CW'(CREDITS);
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            err_r <= err_r | ovf_s;
        end
    end

    assign count    = cnt_r;
    assign overflow = err_r;

endmodule

// File: rtl/eb_credit_tx.sv
// Credit-based transmitter: turns a valid/ready channel into a valid/credit
// link so no combinational backpressure has to cross the long wire. A flit is
// only launched with a credit in hand, so the far-end FIFO cannot overflow.
module eb_credit_tx
    import eb_pkg::*;
#(
    parameter  int DW      = 32,
    parameter  int CREDITS = 4,
    localparam int CW      = credit_width(CREDITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          credit_i,
    output logic [CW-1:0] credits_o,
    output logic          err_o
);

    generate
        if (CREDITS < 1) begin : g_bad_credits
            $error("eb_credit_tx: CREDITS must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_s;
    logic          err_s;
    logic          ready_s;
    logic          send_s;
    logic          valid_r;
    logic [DW-1:0] data_r;

    eb_credit_counter #(
        .CREDITS (CREDITS)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_i),
        .dec      (send_s),
        .count    (cnt_s),
        .overflow (err_s)
    );

    // Ready comes straight from the counter flops; a returning credit only
    // shows up as ready on the following cycle.
    assign ready_s = (cnt_s != {CW{1'b0}});
    assign send_s  = valid_i & ready_s;

    // Link valid is a one-cycle pulse per launched flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= send_s;
        end
    end

    // Link data only loads on a send and otherwise holds, so idle cycles do
    // not toggle the wide register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DW{1'b0}};
        end else if (send_s) begin
            data_r <= data_i;
        end
    end

    assign ready_o   = ready_s;
    assign valid_o   = valid_r;
    assign data_o    = data_r;
    assign credits_o = cnt_s;
    assign err_o     = err_s;

endmodule
